sudoku_uart_cmd_ctrl: RTL

Command sequencer on the Avalon-ST byte interfaces of the RS-232 UART core (from_uart = RX, to_uart = TX). Parses single-byte ASCII commands from the host PC. Loads an 81-cell sudoku board into board storage, dumps it back as ASCII, and starts the solver. Sits between the UART core and the board RAM / solver control.

---
 rtl/sudoku_uart_pkg.sv | 49 ++++
 rtl/sudoku_uart_cmd_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_uart_pkg.sv
// ---------------------------------------------------------------------------
// sudoku_uart_pkg
// Shared constants and types for the sudoku UART command sequencer.
//   - ASCII command / response bytes exchanged with the host PC
//   - board geometry (cells per frame, cell index width)
//   - command sequencer FSM state encoding
//   - helper turning a stored cell value into its ASCII dump character
// ---------------------------------------------------------------------------
package sudoku_uart_pkg;

    // Board geometry: one frame carries every cell of the 9x9 board.
    localparam int            NUM_CELLS = 81;
    localparam int            IDX_W     = 7;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

    // Host commands
    localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_DUMP  = 8'h44;  // 'D'
    localparam logic [7:0] CMD_SOLVE = 8'h53;  // 'S'

    // Single-byte responses
    localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR   = 8'h45;  // 'E'
    localparam logic [7:0] RSP_TMO   = 8'h54;  // 'T'

    // Dump characters
    localparam logic [7:0] ASCII_0   = 8'h30;  // '0'
    localparam logic [7:0] ASCII_Q   = 8'h3F;  // '?'
    localparam logic [7:0] ASCII_LF  = 8'h0A;  // line feed

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DUMP_RD,
        ST_DUMP_TX,
        ST_DUMP_NL,
        ST_RESP
    } state_t;

    // Values 0..9 print as their digit; anything larger cannot be a legal
    // sudoku cell, so it is flagged to the host as '?'.
    function automatic logic [7:0] cell_to_ascii(input logic [3:0] value);
        if (value <= 4'd9) begin
            return ASCII_0 | {4'h0, value};
        end
        return ASCII_Q;
    endfunction

endpackage

// File: rtl/sudoku_uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// sudoku_uart_cmd_ctrl
// Byte-command sequencer between the RS-232 UART core (Avalon-ST) and the
// sudoku board RAM / solver control.
//   'L' + 81 digits : write the board into RAM, answer 'K'
//   'D'             : stream the board back as 81 ASCII digits + LF
//   'S'             : pulse solve_start, answer 'K'
//   anything else   : answer 'E'; a silent load frame answers 'T'
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_rx_data/valid/error   byte stream from the UART receiver
//   o_rx_ready              back-pressure to the UART receiver
//   o_tx_data/valid/error   byte stream to the UART transmitter
//   i_tx_ready              transmitter accepts the presented byte
//   o_cell_addr/wdata/we    board RAM write/read port
//   i_cell_rdata            board RAM read data (1-cycle latency)
//   o_load_done             pulse with the final cell write of a load
//   o_solve_start           pulse on an accepted 'S' command
//   o_busy                  sequencer is not idle
// ---------------------------------------------------------------------------
module sudoku_uart_cmd_ctrl
    import sudoku_uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    input  logic             i_rx_error,
    output logic             o_rx_ready,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    output logic             o_tx_error,
    input  logic             i_tx_ready,
    output logic [IDX_W-1:0] o_cell_addr,
    output logic [3:0]       o_cell_wdata,
    output logic             o_cell_we,
    input  logic [3:0]       i_cell_rdata,
    output logic             o_load_done,
    output logic             o_solve_start,
    output logic             o_busy
);

    localparam logic [31:0] TMO_LIMIT  = 32'(TIMEOUT_CYCLES);
    localparam bit          TMO_ENABLE = (TIMEOUT_CYCLES != 0);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_tmoCnt;
    logic [7:0]       r_txData;
    logic             r_txValid;
    logic [IDX_W-1:0] r_cellAddr;
    logic [3:0]       r_cellWdata;
    logic             r_cellWe;
    logic             r_loadDone;
    logic             r_solveStart;

    state_t           w_state;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_tmoCnt;
    logic [7:0]       w_txData;
    logic             w_txValid;
    logic [IDX_W-1:0] w_cellAddr;
    logic [3:0]       w_cellWdata;
    logic             w_cellWe;
    logic             w_loadDone;
    logic             w_solveStart;

    logic             w_rxAccept;
    logic             w_rxDigit;
    logic             w_txHandshake;

    assign o_rx_ready    = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign w_rxAccept    = i_rx_valid && o_rx_ready;
    assign w_rxDigit     = (i_rx_data[7:4] == 4'h3) && (i_rx_data[3:0] <= 4'd9);
    assign w_txHandshake = r_txValid && i_tx_ready;

    assign o_tx_data     = r_txData;
    assign o_tx_valid    = r_txValid;
    assign o_tx_error    = 1'b0;
    assign o_cell_addr   = r_cellAddr;
    assign o_cell_wdata  = r_cellWdata;
    assign o_cell_we     = r_cellWe;
    assign o_load_done   = r_loadDone;
    assign o_solve_start = r_solveStart;
    assign o_busy        = (r_state != ST_IDLE);

    // State and output registers; every output the host or RAM sees comes
    // straight from a flop.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_tmoCnt     <= '0;
            r_txData     <= '0;
            r_txValid    <= 1'b0;
            r_cellAddr   <= '0;
            r_cellWdata  <= '0;
            r_cellWe     <= 1'b0;
            r_loadDone   <= 1'b0;
            r_solveStart <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_idx        <= w_idx;
            r_tmoCnt     <= w_tmoCnt;
            r_txData     <= w_txData;
            r_txValid    <= w_txValid;
            r_cellAddr   <= w_cellAddr;
            r_cellWdata  <= w_cellWdata;
            r_cellWe     <= w_cellWe;
            r_loadDone   <= w_loadDone;
            r_solveStart <= w_solveStart;
        end
    end

    // Next-state and next-output decode. Strobes default low; everything
    // else holds. Entering RESP always loads a response byte and raises
    // tx_valid in the same step.
    always_comb begin
        w_state      = r_state;
        w_idx        = r_idx;
        w_tmoCnt     = r_tmoCnt;
        w_txData     = r_txData;
        w_txValid    = r_txValid;
        w_cellAddr   = r_cellAddr;
        w_cellWdata  = r_cellWdata;
        w_cellWe     = 1'b0;
        w_loadDone   = 1'b0;
        w_solveStart = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_rxAccept) begin
                    if (i_rx_error) begin
                        // A corrupted byte is never decoded as a command.
                        w_state   = ST_RESP;
                        w_txData  = RSP_ERR;
                        w_txValid = 1'b1;
                    end else begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                w_state  = ST_LOAD;
                                w_idx    = '0;
                                w_tmoCnt = '0;
                            end
                            CMD_DUMP: begin
                                w_state    = ST_DUMP_RD;
                                w_idx      = '0;
                                w_cellAddr = '0;
                            end
                            CMD_SOLVE: begin
                                w_solveStart = 1'b1;
                                w_state      = ST_RESP;
                                w_txData     = RSP_OK;
                                w_txValid    = 1'b1;
                            end
                            default: begin
                                w_state   = ST_RESP;
                                w_txData  = RSP_ERR;
                                w_txValid = 1'b1;
                            end
                        endcase
                    end
                end
            end

            ST_LOAD: begin
                if (w_rxAccept) begin
                    w_tmoCnt = '0;
                    if (i_rx_error || !w_rxDigit) begin
                        // Abort; cells already written are left in RAM.
                        w_state   = ST_RESP;
                        w_txData  = RSP_ERR;
                        w_txValid = 1'b1;
                    end else begin
                        // '0'..'9' are 0x30..0x39, so the low nibble is
                        // already the cell value.
                        w_cellWe    = 1'b1;
                        w_cellAddr  = r_idx;
                        w_cellWdata = i_rx_data[3:0];
                        w_idx       = r_idx + 1'b1;
                        if (r_idx == LAST_IDX) begin
                            w_loadDone = 1'b1;
                            w_state    = ST_RESP;
                            w_txData   = RSP_OK;
                            w_txValid  = 1'b1;
                        end
                    end
                end else if (TMO_ENABLE && (r_tmoCnt == TMO_LIMIT)) begin
                    // An arriving byte is checked first, so it beats the
                    // timeout when both land in the same cycle.
                    w_state   = ST_RESP;
                    w_txData  = RSP_TMO;
                    w_txValid = 1'b1;
                end else begin
                    w_tmoCnt = r_tmoCnt + 32'd1;
                end
            end

            ST_DUMP_RD: begin
                // cell_addr was set to idx on the way in; this cycle gives
                // the RAM its read latency.
                w_state = ST_DUMP_TX;
            end

            ST_DUMP_TX: begin
                if (!r_txValid) begin
                    w_txData  = cell_to_ascii(i_cell_rdata);
                    w_txValid = 1'b1;
                end else if (i_tx_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state  = ST_DUMP_NL;
                        w_txData = ASCII_LF;
                    end else begin
                        w_txValid  = 1'b0;
                        w_idx      = r_idx + 1'b1;
                        w_cellAddr = r_idx + 1'b1;
                        w_state    = ST_DUMP_RD;
                    end
                end
            end

            ST_DUMP_NL, ST_RESP: begin
                if (w_txHandshake) begin
                    w_txValid = 1'b0;
                    w_state   = ST_IDLE;
                end
            end

            default: begin
                w_state   = ST_IDLE;
                w_txValid = 1'b0;
            end
        endcase
    end

endmodule
